// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
package ldm_stm_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CALC = 3'd1,
      S_XFER = 3'd2,
      S_LWR  = 3'd3,
      S_WB   = 3'd4,
      S_FIN  = 3'd5
   } seq_state_t;

   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_SYS = 5'b11111;
   localparam logic [4:0] MODE_FIQ = 5'b10001;

   localparam int unsigned WORD_STEP = 4;

   function automatic logic [15:0] bit_onehot(input logic [3:0] idx);
      return 16'd1 << idx;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_reglist_prio.sv
// Lowest-set-bit priority encoder and population count over a 16-bit register list.
module reglist_prio
   import ldm_stm_seq_pkg::*;
(
   input  logic [15:0] i_list,
   output logic [3:0]  o_idx,
   output logic        o_valid,
   output logic [4:0]  o_count
);

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      o_count = '0;
      // Scanning downwards leaves the lowest set bit as the final winner.
      for (int i = 15; i >= 0; i--) begin
         if (i_list[i]) begin
            o_idx   = 4'(i);
            o_valid = 1'b1;
         end
      end
      for (int i = 0; i < 16; i++) begin
         o_count = o_count + 5'(i_list[i]);
      end
   end

endmodule

// File: rtl/ldm_stm_seq.sv
// ARM LDM/STM sequencer: walks a register list lowest-first with one req/ack beat per register.
// Optional user-bank transfers (S bit) are enabled by defining ARM_LDM_USER_BANK_EN.
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int ADDR = 4,
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            Rst,
   input  logic            start,
   input  logic [15:0]     reg_list,
   input  logic            L,
   input  logic            P,
   input  logic            U,
   input  logic            W,
   input  logic            S,
   input  logic [ADDR-1:0] Rn,
   input  logic [SIZE-1:0] base,
   input  logic [4:0]      M_in,
   input  logic [SIZE-1:0] R_Data_C,
   input  logic [SIZE-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [ADDR-1:0] R_Addr_C,
   output logic [ADDR-1:0] W_Addr,
   output logic [SIZE-1:0] W_Data,
   output logic            Write_Reg,
   output logic            Write_PC,
   output logic [SIZE-1:0] PC_New,
   output logic [4:0]      M_out,
   output logic            mem_req,
   output logic            mem_we,
   output logic [SIZE-1:0] mem_addr,
   output logic [SIZE-1:0] mem_wdata,
   output logic            busy,
   output logic            done
);

   seq_state_t      r_state;
   seq_state_t      w_next;
   logic [15:0]     r_list;
   logic [15:0]     r_list0;
   logic            r_l, r_p, r_u, r_w;
   logic [ADDR-1:0] r_rn;
   logic [SIZE-1:0] r_base;
   logic [SIZE-1:0] r_addr;
   logic [SIZE-1:0] r_newbase;
   logic [3:0]      r_cur;
   logic [SIZE-1:0] r_rdata;

   logic [3:0]      w_idx;
   logic            w_valid;
   logic [4:0]      w_count;
   logic [SIZE-1:0] w_four_n;
   logic [SIZE-1:0] w_start_addr;
   logic [SIZE-1:0] w_newbase;
   logic            w_wb_en;

   reglist_prio u_prio (
      .i_list  (r_list),
      .o_idx   (w_idx),
      .o_valid (w_valid),
      .o_count (w_count)
   );

   assign w_four_n  = SIZE'(w_count) << 2;
   assign w_newbase = r_u ? (r_base + w_four_n) : (r_base - w_four_n);

   always_comb begin
      unique case ({r_p, r_u})
         2'b01:   w_start_addr = r_base;
         2'b11:   w_start_addr = r_base + SIZE'(WORD_STEP);
         2'b00:   w_start_addr = r_base - w_four_n + SIZE'(WORD_STEP);
         default: w_start_addr = r_base - w_four_n;
      endcase
   end

   // A loaded base register keeps the loaded value; R15 as base is never written back.
   assign w_wb_en = r_w && !(r_l && r_list0[r_rn]) && (r_rn != ADDR'(15));

`ifdef ARM_LDM_USER_BANK_EN
   logic r_s;
   logic w_user;
   assign w_user = r_s && (!r_list0[15] || !r_l);
   assign M_out  = (w_user && (r_state == S_XFER || r_state == S_LWR)) ? MODE_USR : M_in;
`else
   logic w_unused_s;
   assign w_unused_s = S;
   assign M_out      = M_in;
`endif

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= S_IDLE;
         r_list    <= '0;
         r_list0   <= '0;
         r_l       <= 1'b0;
         r_p       <= 1'b0;
         r_u       <= 1'b0;
         r_w       <= 1'b0;
         r_rn      <= '0;
         r_base    <= '0;
         r_addr    <= '0;
         r_newbase <= '0;
         r_cur     <= '0;
         r_rdata   <= '0;
`ifdef ARM_LDM_USER_BANK_EN
         r_s       <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_list  <= reg_list;
                  r_list0 <= reg_list;
                  r_l     <= L;
                  r_p     <= P;
                  r_u     <= U;
                  r_w     <= W;
                  r_rn    <= Rn;
                  r_base  <= base;
`ifdef ARM_LDM_USER_BANK_EN
                  r_s     <= S;
`endif
               end
            end
            S_CALC: begin
               r_addr    <= w_start_addr;
               r_newbase <= w_newbase;
            end
            S_XFER: begin
               if (mem_ack) begin
                  r_list  <= r_list & ~bit_onehot(w_idx);
                  r_addr  <= r_addr + SIZE'(WORD_STEP);
                  r_cur   <= w_idx;
                  r_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      R_Addr_C  = '0;
      W_Addr    = '0;
      W_Data    = '0;
      Write_Reg = 1'b0;
      Write_PC  = 1'b0;
      PC_New    = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = (r_state != S_IDLE) && (r_state != S_FIN);
      done      = 1'b0;
      case (r_state)
         S_IDLE: if (start) w_next = S_CALC;
         S_CALC: w_next = w_valid ? S_XFER : S_FIN;
         S_XFER: begin
            mem_req  = 1'b1;
            mem_we   = !r_l;
            mem_addr = {r_addr[SIZE-1:2], 2'b00};
            if (!r_l) begin
               R_Addr_C  = ADDR'(w_idx);
               mem_wdata = R_Data_C;
            end
            if (mem_ack) begin
               if (r_l)              w_next = S_LWR;
               else if (w_count > 1) w_next = S_XFER;
               else                  w_next = S_WB;
            end
         end
         S_LWR: begin
            if (r_cur == 4'd15) begin
               Write_PC = 1'b1;
               PC_New   = {r_rdata[SIZE-1:1], 1'b0};
            end else begin
               Write_Reg = 1'b1;
               W_Addr    = ADDR'(r_cur);
               W_Data    = r_rdata;
            end
            w_next = (r_list != '0) ? S_XFER : S_WB;
         end
         S_WB: begin
            if (w_wb_en) begin
               Write_Reg = 1'b1;
               W_Addr    = r_rn;
               W_Data    = r_newbase;
            end
            w_next = S_FIN;
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: vector table with immediate ack, plus delayed-ack/reset and FIN corner sequences.
module tb_ldm_stm_seq;
   import ldm_stm_seq_pkg::*;

`ifdef ARM_LDM_USER_BANK_EN
   localparam bit UB = 1'b1;
`else
   localparam bit UB = 1'b0;
`endif
   localparam logic [4:0] MODE_SVC = 5'b10011;

   logic        clk = 1'b0;
   logic        Rst, start, L, P, U, W, S, mem_ack;
   logic [15:0] reg_list;
   logic [3:0]  Rn;
   logic [31:0] base, R_Data_C, mem_rdata;
   logic [4:0]  M_in;
   logic [3:0]  R_Addr_C, W_Addr;
   logic [31:0] W_Data, PC_New, mem_addr, mem_wdata;
   logic        Write_Reg, Write_PC, mem_req, mem_we, busy, done;
   logic [4:0]  M_out;

   int checks   = 0;
   int failures = 0;

   ldm_stm_seq #(.ADDR(4), .SIZE(32)) dut (
      .clk(clk), .Rst(Rst), .start(start), .reg_list(reg_list), .L(L), .P(P), .U(U),
      .W(W), .S(S), .Rn(Rn), .base(base), .M_in(M_in), .R_Data_C(R_Data_C),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .R_Addr_C(R_Addr_C), .W_Addr(W_Addr),
      .W_Data(W_Data), .Write_Reg(Write_Reg), .Write_PC(Write_PC), .PC_New(PC_New),
      .M_out(M_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Register file model for port C: Ri holds i+1.
   always_comb R_Data_C = 32'(R_Addr_C) + 32'd1;

   typedef struct {
      logic [15:0] list;
      logic        l, p, u, w, s;
      logic [3:0]  rn;
      logic [31:0] base;
      logic [4:0]  m;
      logic [31:0] rdata;
      logic [31:0] first;
      int          n;
      logic        wb_en;
      logic [31:0] wb_val;
      int          done_cyc;
      logic        s_user;
   } vec_t;

   vec_t vt [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int lowest(input logic [15:0] l);
      for (int i = 0; i < 16; i++) if (l[i]) return i;
      return 0;
   endfunction

   task automatic run_vec(input int vi);
      vec_t        v;
      logic [15:0] rem;
      int          k, cur, last_reg, done_c;
      logic        pend, wb_seen;
      logic [31:0] last_data;
      logic [4:0]  m_beat;
      v = vt[vi];
      m_beat = (UB && v.s_user) ? MODE_USR : v.m;
      @(negedge clk);
      reg_list = v.list; L = v.l; P = v.p; U = v.u; W = v.w; S = v.s;
      Rn = v.rn; base = v.base; M_in = v.m; mem_ack = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      rem = v.list; k = 0; pend = 1'b0; wb_seen = 1'b0; done_c = 0;
      last_reg = 0; last_data = '0;
      for (int c = 1; c <= 60 && done_c == 0; c++) begin
         @(negedge clk);
         mem_rdata = v.rdata + 32'(k);
         if (pend) begin
            pend = 1'b0;
            if (last_reg == 15) begin
               chk($sformatf("v%0d pc_strobe", vi), {31'd0, Write_PC}, 32'd1);
               chk($sformatf("v%0d pc_no_reg", vi), {31'd0, Write_Reg}, 32'd0);
               chk($sformatf("v%0d pc_new", vi), PC_New, last_data & ~32'd1);
            end else begin
               chk($sformatf("v%0d ld_strobe", vi), {31'd0, Write_Reg}, 32'd1);
               chk($sformatf("v%0d ld_waddr", vi), 32'(W_Addr), 32'(last_reg));
               chk($sformatf("v%0d ld_wdata", vi), W_Data, last_data);
               chk($sformatf("v%0d ld_mode", vi), 32'(M_out), 32'(m_beat));
            end
         end else if (Write_Reg || Write_PC) begin
            wb_seen = 1'b1;
            chk($sformatf("v%0d wb_pc", vi), {31'd0, Write_PC}, 32'd0);
            chk($sformatf("v%0d wb_addr", vi), 32'(W_Addr), 32'(v.rn));
            chk($sformatf("v%0d wb_data", vi), W_Data, v.wb_val);
            chk($sformatf("v%0d wb_mode", vi), 32'(M_out), 32'(v.m));
         end
         if (mem_req) begin
            cur = lowest(rem);
            chk($sformatf("v%0d addr%0d", vi, k), mem_addr, v.first + 32'(4 * k));
            chk($sformatf("v%0d we%0d", vi, k), {31'd0, mem_we}, {31'd0, !v.l});
            chk($sformatf("v%0d mode%0d", vi, k), 32'(M_out), 32'(m_beat));
            if (!v.l) begin
               chk($sformatf("v%0d raddr%0d", vi, k), 32'(R_Addr_C), 32'(cur));
               chk($sformatf("v%0d wdata%0d", vi, k), mem_wdata, 32'(cur) + 32'd1);
            end else begin
               pend = 1'b1;
               last_reg = cur;
               last_data = mem_rdata;
            end
            rem[cur] = 1'b0;
            k++;
         end
         if (done) begin
            done_c = c;
            chk($sformatf("v%0d busy_at_done", vi), {31'd0, busy}, 32'd0);
         end
      end
      chk($sformatf("v%0d done_cycle", vi), 32'(done_c), 32'(v.done_cyc));
      chk($sformatf("v%0d beats", vi), 32'(k), 32'(v.n));
      chk($sformatf("v%0d wb_seen", vi), {31'd0, wb_seen}, {31'd0, v.wb_en});
   endtask

   initial begin
      //          list      l     p     u     w     s     rn     base          m         rdata         first         n  wb    wb_val        done user
      vt[0]  = '{16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4,  32'h0000_0100, MODE_SYS, 32'h0,        32'h0000_0100, 3, 1'b1, 32'h0000_010C, 6, 1'b0};
      vt[1]  = '{16'h8003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  32'h0000_0200, MODE_SVC, 32'h0000_1001, 32'h0000_01F4, 3, 1'b0, 32'h0,        9, 1'b0};
      vt[2]  = '{16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1,  32'h0000_0300, MODE_SVC, 32'h0000_DEAD, 32'h0000_0300, 1, 1'b0, 32'h0,        5, 1'b0};
      vt[3]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2,  32'h0000_0400, MODE_SVC, 32'h0,        32'h0,         0, 1'b0, 32'h0,        2, 1'b0};
      vt[4]  = '{16'h0011, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd2,  32'h0000_0500, MODE_SVC, 32'h0,        32'h0000_0504, 2, 1'b1, 32'h0000_0508, 5, 1'b0};
      vt[5]  = '{16'h0C00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3,  32'h0000_0600, MODE_SVC, 32'h0,        32'h0000_05FC, 2, 1'b1, 32'h0000_05F8, 5, 1'b0};
      vt[6]  = '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 32'h0000_0700, MODE_SVC, 32'h0,        32'h0000_0700, 1, 1'b0, 32'h0,        4, 1'b0};
      vt[7]  = '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3,  32'h0000_0103, MODE_SVC, 32'h0,        32'h0000_0100, 1, 1'b0, 32'h0,        4, 1'b0};
      vt[8]  = '{16'h0003, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6,  32'h0000_0004, MODE_SVC, 32'h0,        32'hFFFF_FFFC, 2, 1'b1, 32'hFFFF_FFFC, 5, 1'b0};
      vt[9]  = '{16'h0300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7,  32'h0000_0800, MODE_FIQ, 32'h0,        32'h0000_0800, 2, 1'b1, 32'h0000_0808, 5, 1'b1};
      vt[10] = '{16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8,  32'h0000_0900, MODE_FIQ, 32'h0000_2000, 32'h0000_0900, 1, 1'b0, 32'h0,        5, 1'b0};
      vt[11] = '{16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0,  32'h0000_0A00, MODE_FIQ, 32'h0000_0055, 32'h0000_0A00, 1, 1'b1, 32'h0000_0A04, 5, 1'b1};

      Rst = 1'b0; start = 1'b0; reg_list = '0; L = 0; P = 0; U = 0; W = 0; S = 0;
      Rn = '0; base = '0; M_in = MODE_FIQ; mem_ack = 1'b0; mem_rdata = '0;
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_wreg", {31'd0, Write_Reg}, 32'd0);
      chk("rst_mode", 32'(M_out), 32'(MODE_FIQ));
      @(negedge clk);
      Rst = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(i);

      // Start held high through CALC and FIN must not relaunch.
      @(negedge clk);
      reg_list = 16'h0000; W = 1'b0; start = 1'b1;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("fin_start_ignored", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("fin_no_done", {31'd0, done}, 32'd0);

      // Delayed ack: beat outputs hold until ack, then reset aborts mid-transfer.
      @(negedge clk);
      reg_list = 16'h0003; L = 0; P = 0; U = 1; W = 1; S = 0; Rn = 4'd2;
      base = 32'h0000_0040; M_in = MODE_SVC; mem_ack = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("dly_req", {31'd0, mem_req}, 32'd1);
      chk("dly_addr", mem_addr, 32'h0000_0040);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("dly_hold_addr%0d", i), mem_addr, 32'h0000_0040);
         chk($sformatf("dly_hold_wdata%0d", i), mem_wdata, 32'd1);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("dly_beat1_addr", mem_addr, 32'h0000_0044);
      chk("dly_beat1_wdata", mem_wdata, 32'd2);
      #2 Rst = 1'b0;
      #1;
      chk("abort_req", {31'd0, mem_req}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_wreg", {31'd0, Write_Reg}, 32'd0);
      @(negedge clk);
      Rst = 1'b1;
      mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("post_abort_idle%0d", i), {29'd0, busy, mem_req, Write_Reg}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
